// File: rtl/pipeline_if_stage_pkg.sv
// pipeline_if_stage_pkg: shared constants, FSM encoding and fetch-entry type for the IF stage.
package pipeline_if_stage_pkg;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] BUFFERED = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: one-entry holding slot for a word that arrived while decode was stalled.
module if_fetch_buf
  import pipeline_if_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   drain,
  input  logic   clear,
  input  fetch_t din,
  output fetch_t dout,
  output logic   valid
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      dout <= '0;
    end else if (clear || drain) valid <= 1'b0;
    else if (load) begin
      valid <= 1'b1;
      dout <= din;
    end
endmodule

// File: rtl/pipeline_if_stage.sv
// pipeline_if_stage: instruction fetch with stall buffering and redirect flush/drain.
module pipeline_if_stage
  import pipeline_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk_IF,
  input  logic        rst_IF,
  input  logic        stall_IF,
  input  logic        redirect_IF,
  input  logic [31:0] PC_target_IF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out_IF,
  output logic [31:0] PC_out_IF,
  output logic        valid_out_IF
);
  logic [1:0] state;
  logic [31:0] pc, pending, target;
  logic buf_load, buf_drain, buf_valid;
  fetch_t buf_out;
  assign target = word_align(PC_target_IF);
  // pc is never advanced while a request is outstanding, so it is also the DRAIN address
  assign imem_req = !rst_IF && state != BUFFERED;
  assign imem_addr = pc;
  assign buf_load = state == FETCH && imem_ready && stall_IF && !redirect_IF;
  assign buf_drain = state == BUFFERED && buf_valid && !stall_IF && !redirect_IF;
  if_fetch_buf u_buf (
    .clk(clk_IF), .rst(rst_IF), .load(buf_load), .drain(buf_drain), .clear(redirect_IF),
    .din('{inst: imem_rdata, pc: pc}), .dout(buf_out), .valid(buf_valid)
  );
  always_ff @(posedge clk_IF or posedge rst_IF)
    if (rst_IF) begin
      state <= FETCH;
      pc <= RESET_PC;
      pending <= '0;
      inst_out_IF <= NOP_INST;
      PC_out_IF <= '0;
      valid_out_IF <= 1'b0;
    end else if (redirect_IF) begin
      inst_out_IF <= NOP_INST;
      valid_out_IF <= 1'b0;
      if (state == DRAIN) begin
        pending <= target;
        if (imem_ready) begin
          pc <= target;
          state <= FETCH;
        end
      end else if (state == FETCH && !imem_ready) begin
        pending <= target;
        state <= DRAIN;
      end else begin
        pc <= target;
        state <= FETCH;
      end
    end else if (state == DRAIN) begin
      if (imem_ready) begin
        pc <= pending;
        state <= FETCH;
      end
    end else if (buf_drain) begin
      inst_out_IF <= buf_out.inst;
      PC_out_IF <= buf_out.pc;
      valid_out_IF <= 1'b1;
      pc <= pc + 32'd4;
      state <= FETCH;
    end else if (state == FETCH && !stall_IF) begin
      inst_out_IF <= imem_ready ? imem_rdata : NOP_INST;
      PC_out_IF <= imem_ready ? pc : PC_out_IF;
      valid_out_IF <= imem_ready;
      pc <= imem_ready ? pc + 32'd4 : pc;
    end else if (buf_load) state <= BUFFERED;
endmodule

// File: tb/tb_pipeline_if_stage.sv
// tb_pipeline_if_stage: directed vectors plus a fetch-stream model checked every cycle.
module tb_pipeline_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk_IF = 1'b0;
  logic rst_IF = 1'b1;
  logic stall_IF = 1'b0;
  logic redirect_IF = 1'b0;
  logic [31:0] PC_target_IF = '0;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out_IF, PC_out_IF;
  logic valid_out_IF;
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_BEE0;
  endfunction

  assign imem_rdata = mem(imem_addr);

  pipeline_if_stage dut (
    .clk_IF(clk_IF), .rst_IF(rst_IF), .stall_IF(stall_IF), .redirect_IF(redirect_IF),
    .PC_target_IF(PC_target_IF), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .inst_out_IF(inst_out_IF),
    .PC_out_IF(PC_out_IF), .valid_out_IF(valid_out_IF)
  );

  always #5 clk_IF = ~clk_IF;

  // Model: next fetch address, a parked word, a redirect waiting for its stale response.
  logic [31:0] m_pc, m_buf_word, m_buf_pc, m_tgt, m_inst, m_ipc;
  bit m_buf, m_drain, m_valid;
  always @(posedge clk_IF or posedge rst_IF) begin
    if (rst_IF) begin
      m_pc = 32'h0; m_buf = 0; m_drain = 0; m_tgt = 0;
      m_inst = NOP; m_ipc = 0; m_valid = 0;
    end else if (redirect_IF) begin
      m_inst = NOP; m_valid = 0;
      if (m_drain) begin
        m_tgt = PC_target_IF & ~32'h3;
        if (imem_ready) begin m_drain = 0; m_pc = m_tgt; end
      end else if (m_buf) begin
        m_buf = 0; m_pc = PC_target_IF & ~32'h3;
      end else if (imem_ready) m_pc = PC_target_IF & ~32'h3;
      else begin m_drain = 1; m_tgt = PC_target_IF & ~32'h3; end
    end else if (m_drain) begin
      if (imem_ready) begin m_drain = 0; m_pc = m_tgt; end
    end else if (m_buf) begin
      if (!stall_IF) begin
        m_inst = m_buf_word; m_ipc = m_buf_pc; m_valid = 1; m_buf = 0; m_pc = m_pc + 4;
      end
    end else if (stall_IF) begin
      if (imem_ready) begin m_buf = 1; m_buf_word = mem(m_pc); m_buf_pc = m_pc; end
    end else if (imem_ready) begin
      m_inst = mem(m_pc); m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 4;
    end else begin
      m_inst = NOP; m_valid = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk_IF);
    #1;
    chk("model inst", inst_out_IF, m_inst);
    chk("model pc_out", PC_out_IF, m_ipc);
    chk("model valid", {31'b0, valid_out_IF}, {31'b0, m_valid});
    chk("model req", {31'b0, imem_req}, {31'b0, !rst_IF && !m_buf});
    if (!rst_IF && !m_buf) chk("model addr", imem_addr, m_pc);
  end

  task automatic drive(input logic rs, input logic st, input logic rd, input logic rdy,
                       input logic [31:0] tgt);
    rst_IF = rs; stall_IF = st; redirect_IF = rd; imem_ready = rdy; PC_target_IF = tgt;
    @(posedge clk_IF);
    #2;
  endtask

  task automatic ifid(input string name, input logic [31:0] i, input logic [31:0] p,
                      input logic v);
    chk({name, " inst"}, inst_out_IF, i);
    chk({name, " pc"}, PC_out_IF, p);
    chk({name, " valid"}, {31'b0, valid_out_IF}, {31'b0, v});
  endtask

  initial begin
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    ifid("reset", NOP, 32'h0, 0);
    chk("reset req", {31'b0, imem_req}, 32'h0);
    drive(0, 0, 0, 1, 0);
    ifid("seq0", 32'hDEAD_BEE0, 32'h0, 1);
    drive(0, 0, 0, 1, 0);
    ifid("seq4", 32'hDEAD_BEE4, 32'h4, 1);
    drive(0, 0, 0, 1, 0);
    ifid("seq8", 32'hDEAD_BEE8, 32'h8, 1);
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 0);
      ifid("stall hold", 32'hDEAD_BEE4, 32'h4, 1);
      chk("stall req", {31'b0, imem_req}, 32'h0);
    end
    drive(0, 0, 0, 1, 0);
    ifid("stall release", 32'hDEAD_BEE8, 32'h8, 1);
    drive(0, 0, 0, 1, 0);
    ifid("after release", 32'hDEAD_BEEC, 32'hC, 1);
    drive(0, 0, 1, 1, 32'h103);
    ifid("redirect flush", NOP, 32'hC, 0);
    chk("redirect addr", imem_addr, 32'h100);
    drive(0, 0, 0, 1, 0);
    ifid("redirect first", 32'hDEAD_BFE0, 32'h100, 1);
    drive(0, 0, 1, 1, 32'h10);
    drive(0, 0, 1, 0, 32'h200);
    chk("drain addr a", imem_addr, 32'h10);
    drive(0, 0, 0, 0, 0);
    chk("drain addr b", imem_addr, 32'h10);
    chk("drain req", {31'b0, imem_req}, 32'h1);
    drive(0, 0, 0, 1, 0);
    chk("drain target", imem_addr, 32'h200);
    chk("drain dropped", {31'b0, valid_out_IF}, 32'h0);
    drive(0, 0, 0, 1, 0);
    ifid("drain first", 32'hDEAD_BCE0, 32'h200, 1);
    drive(0, 1, 1, 1, 32'h300);
    chk("redir+stall valid", {31'b0, valid_out_IF}, 32'h0);
    chk("redir+stall addr", imem_addr, 32'h300);
    drive(0, 1, 0, 1, 0);
    drive(0, 1, 1, 1, 32'h40);
    chk("buf redirect valid", {31'b0, valid_out_IF}, 32'h0);
    chk("buf redirect addr", imem_addr, 32'h40);
    drive(0, 0, 1, 1, 32'hFFFF_FFFC);
    drive(0, 0, 0, 1, 0);
    ifid("wrap top", 32'h2152_411C, 32'hFFFF_FFFC, 1);
    chk("wrap addr", imem_addr, 32'h0);
    drive(0, 1, 0, 1, 0);
    rst_IF = 1'b1;
    #1;
    ifid("async reset", NOP, 32'h0, 0);
    chk("async reset req", {31'b0, imem_req}, 32'h0);
    @(posedge clk_IF);
    #2;
    drive(0, 0, 0, 1, 0);
    ifid("post reset", 32'hDEAD_BEE0, 32'h0, 1);
    for (int i = 0; i < 80; i++)
      drive(0, $urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(2) != 0, $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_if_stage.md
PIPELINE_IF_STAGE -- requirements
Module: pipeline_if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), the bubble instruction.
REQ-003 SHALL have port clk_IF, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_IF, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port stall_IF, input, 1, hazard hold: IF/ID register and PC hold.
REQ-006 SHALL have port redirect_IF, input, 1, branch/jump taken in a later stage; flushes IF/ID.
REQ-007 SHALL have port PC_target_IF, input, 32, redirect address; bits [1:0] ignored (treated as 0).
REQ-008 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-009 SHALL have port imem_addr, output, 32, fetch address; stable while imem_req=1 and imem_ready=0.
REQ-010 SHALL have port imem_ready, input, 1, response strobe; imem_rdata valid in the same cycle.
REQ-011 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-012 SHALL have port inst_out_IF, output, 32, IF/ID instruction, drives the decode stage instruction input.
REQ-013 SHALL have port PC_out_IF, output, 32, PC of inst_out_IF.
REQ-014 SHALL have port valid_out_IF, output, 1, 1 = inst_out_IF is a real instruction, 0 = bubble.

Function
REQ-015 SHALL implement states FETCH, BUFFERED, DRAIN; imem_req=1 in FETCH and DRAIN, 0 in BUFFERED.
REQ-016 SHALL drive imem_addr from PC register in FETCH and from the outstanding address in DRAIN.
REQ-017 FETCH, imem_ready=1, stall=0, redirect=0: SHALL load IF/ID with {imem_rdata, PC, valid=1}, PC<=PC+4.
REQ-018 FETCH, imem_ready=0, stall=0, redirect=0: SHALL load IF/ID with {NOP_INST, PC_out unchanged, valid=0}; PC holds.
REQ-019 FETCH, imem_ready=1, stall=1, redirect=0: SHALL capture {imem_rdata, PC} in a one-entry buffer, go to BUFFERED; IF/ID holds.
REQ-020 BUFFERED, stall=0, redirect=0: SHALL move buffer into IF/ID with valid=1, PC<=PC+4, return to FETCH.
REQ-021 Any state, stall=1 and no redirect: IF/ID and PC SHALL hold.
REQ-022 redirect=1 SHALL take priority over stall: IF/ID <= {NOP_INST, valid=0}, buffer discarded.
REQ-023 redirect=1 in FETCH with imem_ready=1 or in BUFFERED: PC<=PC_target with [1:0]=0, next state FETCH, response discarded.
REQ-024 redirect=1 in FETCH with imem_ready=0: SHALL latch target as pending, go to DRAIN, keep imem_addr stable.
REQ-025 DRAIN: SHALL discard the response on imem_ready=1, then PC<=pending target, go to FETCH; a new redirect in DRAIN overwrites pending.
REQ-026 PC increment SHALL be modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0).
REQ-027 Fetch-to-IF/ID latency SHALL be one edge after imem_ready in FETCH with stall=0.
REQ-028 valid_out_IF=1 SHALL never be produced for a word fetched from a pre-redirect address.

Reset
REQ-029 While rst_IF=1: PC=RESET_PC, state=FETCH, inst_out_IF=NOP_INST, PC_out_IF=0, valid_out_IF=0, buffer empty, pending=0, imem_req=0.
REQ-030 Reset asserted mid-DRAIN or mid-BUFFERED SHALL abandon the transaction; first request after release uses RESET_PC.

Structure
REQ-031 NOP_INST, RESET_PC default and state encoding SHALL live in the shared pipeline package.
REQ-032 The one-entry fetch buffer SHALL be a sub-module named if_fetch_buf (load, drain, clear, valid).

Verification
REQ-033 Reset release, imem_ready always 1: inst_out_IF words from 0x0,0x4,0x8 on consecutive edges, valid=1.
REQ-034 stall_IF=1 for 3 cycles with ready=1 at PC 0x8: IF/ID holds PC 0x4; after release PC_out 0x8, then 0xC; no word lost or duplicated.
REQ-035 redirect_IF=1, target 0x103 while ready=1: next IF/ID valid=0 inst 0x00000013; next fetch address 0x100.
REQ-036 redirect target 0x200 while request to 0x10 waits 2 cycles: imem_addr stays 0x10, its data dropped, then imem_addr=0x200.
REQ-037 redirect and stall both 1: flush occurs, valid_out_IF=0, PC=target.
REQ-038 PC preset 0xFFFFFFFC, ready=1: next fetch address 0x00000000; rst_IF pulse in BUFFERED: outputs at reset values within same cycle.
